wb_stage_pipe: RTL and testbench

Registered, handshaked successor to the combinational writeback stage of the 5-stage MIPS CPU. It sits between the MEM stage and the register file. It captures one MEM result per accepted transfer and performs load extraction at capture time. LWL/LWR merges leave the CPU as byte-strobed partial writes instead of read-modify-write with rt. The stage owns the architectural HI/LO registers and commits MD/MTHI/MTLO results on retirement.

---
 rtl/cpu_defs_pkg.sv | 23 ++
 rtl/load_align.sv | 43 ++++
 rtl/wb_stage_pipe.sv | 137 +++++++++++++
 tb/tb_wb_stage_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared CPU codes for load types and multiply/divide ops
package cpu_defs_pkg;

    localparam int REG_ADDR_W_DEF = 6;

    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LB  = 3'd1,
        LT_LBU = 3'd2,
        LT_LH  = 3'd3,
        LT_LHU = 3'd4,
        LT_LWL = 3'd5,
        LT_LWR = 3'd6
    } load_type_e;

    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_HILO = 2'd1,
        MD_MTHI = 2'd2,
        MD_MTLO = 2'd3
    } md_op_e;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - load data extraction and byte-strobe generation
module load_align
    import cpu_defs_pkg::*;
(
    input  logic [2:0]  load_type,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data,
    output logic [3:0]  strb
);

    logic [31:0] byte_shifted;
    logic [15:0] half_sel;
    logic [1:0]  lwl_shift;

    always_comb begin
        byte_shifted = rdata >> {offset, 3'b000};
        half_sel     = offset[1] ? rdata[31:16] : rdata[15:0];
        // 3 - offset on a 2-bit value is simply its complement
        lwl_shift    = ~offset;
        data         = rdata;
        strb         = 4'b1111;
        case (load_type)
            LT_LB:  data = {{24{byte_shifted[7]}}, byte_shifted[7:0]};
            LT_LBU: data = {24'd0, byte_shifted[7:0]};
            LT_LH:  data = {{16{half_sel[15]}}, half_sel};
            LT_LHU: data = {16'd0, half_sel};
            LT_LWL: begin
                data = rdata << {lwl_shift, 3'b000};
                strb = 4'b1111 << lwl_shift;
            end
            LT_LWR: begin
                data = rdata >> {offset, 3'b000};
                strb = 4'b1111 >> offset;
            end
            default: begin
                data = rdata;
                strb = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// rtl/wb_stage_pipe.sv - registered handshaked writeback stage with HI/LO ownership
module wb_stage_pipe
    import cpu_defs_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int HILO_EN    = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic                  mem_reg_en,
    input  logic [REG_ADDR_W-1:0] mem_reg_waddr,
    input  logic                  mem_is_load,
    input  logic [2:0]            mem_load_type,
    input  logic [31:0]           mem_alu_result,
    input  logic [31:0]           mem_rdata,
    input  logic [1:0]            mem_md_op,
    input  logic [63:0]           mem_md_result,
    input  logic                  rf_ready,
    output logic                  wb_valid,
    output logic                  wb_reg_en,
    output logic [REG_ADDR_W-1:0] wb_reg_waddr,
    output logic [31:0]           wb_reg_wdata,
    output logic [3:0]            wb_reg_wstrb,
    output logic [31:0]           hi,
    output logic [31:0]           lo
);

    logic                  valid_q,  valid_d;
    logic                  reg_en_q, reg_en_d;
    logic [REG_ADDR_W-1:0] waddr_q,  waddr_d;
    logic [31:0]           wdata_q,  wdata_d;
    logic [3:0]            wstrb_q,  wstrb_d;
    md_op_e                md_op_q,  md_op_d;
    logic [31:0]           md_hi_q,  md_hi_d;
    logic [31:0]           md_lo_q,  md_lo_d;
    logic [31:0]           hi_q,     hi_d;
    logic [31:0]           lo_q,     lo_d;

    logic [31:0] la_data;
    logic [3:0]  la_strb;
    logic        accept;
    logic        retire;

    load_align u_load_align (
        .load_type (mem_load_type),
        .offset    (mem_alu_result[1:0]),
        .rdata     (mem_rdata),
        .data      (la_data),
        .strb      (la_strb)
    );

    assign mem_ready = !valid_q || rf_ready;

    always_comb begin
        accept   = mem_valid && mem_ready && !flush;
        retire   = valid_q && rf_ready && !flush;
        valid_d  = valid_q;
        reg_en_d = reg_en_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        md_op_d  = md_op_q;
        md_hi_d  = md_hi_q;
        md_lo_d  = md_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (retire) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            reg_en_d = mem_reg_en;
            waddr_d  = mem_reg_waddr;
            wdata_d  = mem_is_load ? la_data : mem_alu_result;
            wstrb_d  = mem_is_load ? la_strb : 4'b1111;
            md_op_d  = md_op_e'(mem_md_op);
            // MTHI/MTLO source the ALU result; a full HI/LO write sources the MD unit
            md_hi_d  = (md_op_e'(mem_md_op) == MD_HILO) ? mem_md_result[63:32] : mem_alu_result;
            md_lo_d  = (md_op_e'(mem_md_op) == MD_HILO) ? mem_md_result[31:0]  : mem_alu_result;
        end

        if (retire && (HILO_EN != 0)) begin
            case (md_op_q)
                MD_HILO: begin
                    hi_d = md_hi_q;
                    lo_d = md_lo_q;
                end
                MD_MTHI: hi_d = md_hi_q;
                MD_MTLO: lo_d = md_lo_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q  <= 1'b0;
            reg_en_q <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            md_op_q  <= MD_NONE;
            md_hi_q  <= '0;
            md_lo_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            reg_en_q <= reg_en_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            md_op_q  <= md_op_d;
            md_hi_q  <= md_hi_d;
            md_lo_q  <= md_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign wb_valid     = valid_q;
    assign wb_reg_en    = valid_q & reg_en_q;
    assign wb_reg_waddr = waddr_q;
    assign wb_reg_wdata = wdata_q;
    assign wb_reg_wstrb = wstrb_q;
    assign hi           = (HILO_EN != 0) ? hi_q : 32'd0;
    assign lo           = (HILO_EN != 0) ? lo_q : 32'd0;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb/tb_wb_stage_pipe.sv - directed self-checking bench for wb_stage_pipe
module tb_wb_stage_pipe;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_reg_en;
    logic [5:0]  mem_reg_waddr;
    logic        mem_is_load;
    logic [2:0]  mem_load_type;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_md_op;
    logic [63:0] mem_md_result;
    logic        rf_ready;
    logic        wb_valid;
    logic        wb_reg_en;
    logic [5:0]  wb_reg_waddr;
    logic [31:0] wb_reg_wdata;
    logic [3:0]  wb_reg_wstrb;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_stage_pipe #(.REG_ADDR_W(6), .HILO_EN(1)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_reg_en     (mem_reg_en),
        .mem_reg_waddr  (mem_reg_waddr),
        .mem_is_load    (mem_is_load),
        .mem_load_type  (mem_load_type),
        .mem_alu_result (mem_alu_result),
        .mem_rdata      (mem_rdata),
        .mem_md_op      (mem_md_op),
        .mem_md_result  (mem_md_result),
        .rf_ready       (rf_ready),
        .wb_valid       (wb_valid),
        .wb_reg_en      (wb_reg_en),
        .wb_reg_waddr   (wb_reg_waddr),
        .wb_reg_wdata   (wb_reg_wdata),
        .wb_reg_wstrb   (wb_reg_wstrb),
        .hi             (hi),
        .lo             (lo)
    );

    task automatic set_in(input logic v, input logic ld, input logic [2:0] lt,
                          input logic [31:0] alu, input logic [31:0] rd,
                          input logic [1:0] op, input logic [63:0] res,
                          input logic [5:0] wa, input logic ren);
        mem_valid      = v;
        mem_is_load    = ld;
        mem_load_type  = lt;
        mem_alu_result = alu;
        mem_rdata      = rd;
        mem_md_op      = op;
        mem_md_result  = res;
        mem_reg_waddr  = wa;
        mem_reg_en     = ren;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0; flush = 1'b0; rf_ready = 1'b1;
        set_in(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 2'd0, 64'h0, 6'd0, 1'b0);
        step(); step();
        @(negedge clk);
        resetn = 1'b1;
        n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", wb_valid); end
        n_tests++; if (wb_reg_en !== 1'b0) begin n_fail++; $display("FAIL reset_reg_en got %b exp 0", wb_reg_en); end
        n_tests++; if (wb_reg_waddr !== 6'd0 || wb_reg_wdata !== 32'd0 || wb_reg_wstrb !== 4'd0) begin
            n_fail++; $display("FAIL reset_fields got %h/%h/%b exp 0/0/0", wb_reg_waddr, wb_reg_wdata, wb_reg_wstrb); end
        n_tests++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL reset_hilo got %h/%h exp 0/0", hi, lo); end
        n_tests++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mem_ready got %b exp 1", mem_ready); end
    endtask

    task automatic test_lb();
        @(negedge clk);
        set_in(1'b1, 1'b1, 3'd1, 32'h0000_1003, 32'h80FF_0000, 2'd0, 64'h0, 6'd5, 1'b1);
        step();
        n_tests++; if (wb_valid !== 1'b1 || wb_reg_en !== 1'b1 || wb_reg_waddr !== 6'd5) begin
            n_fail++; $display("FAIL lb_ctrl got v=%b en=%b wa=%0d exp 1 1 5", wb_valid, wb_reg_en, wb_reg_waddr); end
        n_tests++; if (wb_reg_wdata !== 32'hFFFF_FF80 || wb_reg_wstrb !== 4'b1111) begin
            n_fail++; $display("FAIL lb_data got %h/%b exp ffffff80/1111", wb_reg_wdata, wb_reg_wstrb); end
    endtask

    task automatic test_extract();
        logic [2:0]  lt  [6] = '{3'd5, 3'd6, 3'd3, 3'd4, 3'd2, 3'd7};
        logic [31:0] alu [6] = '{32'h1, 32'h2, 32'h2, 32'h0, 32'h1, 32'h3};
        logic [31:0] rd  [6] = '{32'hAABB_CCDD, 32'hAABB_CCDD, 32'h8001_1234, 32'h8001_1234, 32'hAABB_CCDD, 32'h1357_9BDF};
        logic [31:0] exd [6] = '{32'hCCDD_0000, 32'h0000_AABB, 32'hFFFF_8001, 32'h0000_1234, 32'h0000_00CC, 32'h1357_9BDF};
        logic [3:0]  exs [6] = '{4'b1100, 4'b0011, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_in(1'b1, 1'b1, lt[i], alu[i], rd[i], 2'd0, 64'h0, 6'd7, 1'b1);
            step();
            n_tests++; if (wb_valid !== 1'b1 || wb_reg_wdata !== exd[i] || wb_reg_wstrb !== exs[i]) begin
                n_fail++; $display("FAIL extract_%0d got v=%b %h/%b exp 1 %h/%b", i, wb_valid, wb_reg_wdata, wb_reg_wstrb, exd[i], exs[i]); end
        end
        @(negedge clk);
        set_in(1'b1, 1'b0, 3'd1, 32'hDEAD_BEEF, 32'h0, 2'd0, 64'h0, 6'd9, 1'b0);
        step();
        n_tests++; if (wb_reg_wdata !== 32'hDEAD_BEEF || wb_reg_wstrb !== 4'b1111 || wb_reg_en !== 1'b0) begin
            n_fail++; $display("FAIL nonload got %h/%b en=%b exp deadbeef/1111 en=0", wb_reg_wdata, wb_reg_wstrb, wb_reg_en); end
        @(negedge clk);
        mem_valid = 1'b0;
        step();
        n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got %b exp 0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        rf_ready = 1'b0;
        set_in(1'b1, 1'b0, 3'd0, 32'h1111_1111, 32'h0, 2'd0, 64'h0, 6'd1, 1'b1);
        step();
        @(negedge clk);
        set_in(1'b1, 1'b0, 3'd0, 32'h2222_2222, 32'h0, 2'd0, 64'h0, 6'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (wb_valid !== 1'b1 || wb_reg_wdata !== 32'h1111_1111 || wb_reg_waddr !== 6'd1 || mem_ready !== 1'b0) begin
                n_fail++; $display("FAIL hold_%0d got v=%b %h wa=%0d rdy=%b exp 1 11111111 1 0", i, wb_valid, wb_reg_wdata, wb_reg_waddr, mem_ready); end
            step();
        end
        @(negedge clk);
        rf_ready = 1'b1;
        #1;
        n_tests++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready got %b exp 1", mem_ready); end
        step();
        n_tests++; if (wb_valid !== 1'b1 || wb_reg_wdata !== 32'h2222_2222 || wb_reg_waddr !== 6'd2) begin
            n_fail++; $display("FAIL b2b_second got v=%b %h wa=%0d exp 1 22222222 2", wb_valid, wb_reg_wdata, wb_reg_waddr); end
        @(negedge clk);
        mem_valid = 1'b0;
        step();
        n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b exp 0", wb_valid); end
    endtask

    task automatic test_flush_md();
        @(negedge clk);
        rf_ready = 1'b0;
        set_in(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 2'd1, 64'h1234_5678_9ABC_DEF0, 6'd0, 1'b0);
        step();
        @(negedge clk);
        flush = 1'b1; rf_ready = 1'b1;
        set_in(1'b1, 1'b0, 3'd0, 32'h5555_5555, 32'h0, 2'd2, 64'h0, 6'd3, 1'b1);
        step();
        n_tests++; if (wb_valid !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++; $display("FAIL flush got v=%b hi=%h lo=%h exp 0 0 0", wb_valid, hi, lo); end
        @(negedge clk);
        flush = 1'b0;
        set_in(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 2'd1, 64'h1234_5678_9ABC_DEF0, 6'd0, 1'b0);
        step();
        n_tests++; if (wb_valid !== 1'b1 || hi !== 32'd0) begin n_fail++; $display("FAIL md_pre_retire got v=%b hi=%h exp 1 0", wb_valid, hi); end
        @(negedge clk);
        set_in(1'b1, 1'b0, 3'd0, 32'hCAFE_0000, 32'h0, 2'd2, 64'h0, 6'd0, 1'b0);
        step();
        n_tests++; if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
            n_fail++; $display("FAIL md_commit got %h/%h exp 12345678/9abcdef0", hi, lo); end
        @(negedge clk);
        mem_valid = 1'b0;
        step();
        n_tests++; if (hi !== 32'hCAFE_0000 || lo !== 32'h9ABC_DEF0) begin
            n_fail++; $display("FAIL mthi got %h/%h exp cafe0000/9abcdef0", hi, lo); end
    endtask

    task automatic test_reset_mtlo();
        @(negedge clk);
        resetn = 1'b0;
        set_in(1'b1, 1'b0, 3'd0, 32'h5, 32'h0, 2'd3, 64'h0, 6'd4, 1'b1);
        step();
        n_tests++; if (wb_valid !== 1'b0 || lo !== 32'd0 || hi !== 32'd0) begin
            n_fail++; $display("FAIL reset_mtlo got v=%b hi=%h lo=%h exp 0 0 0", wb_valid, hi, lo); end
        @(negedge clk);
        resetn = 1'b1;
        mem_valid = 1'b0;
        step();
        n_tests++; if (wb_valid !== 1'b0 || lo !== 32'd0) begin
            n_fail++; $display("FAIL post_reset got v=%b lo=%h exp 0 0", wb_valid, lo); end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_extract();
        test_back_to_back();
        test_flush_md();
        test_reset_mtlo();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
